// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex display scanner: shows a selected register and/or the PC on
// N_DIG seven-segment digits, with paging, a freeze snapshot and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int N_DIG    = 4,
    parameter int N_REG    = 15,
    parameter int REG_W    = 32,
    parameter int SCAN_DIV = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REG*REG_W-1:0] rf,
    input  logic [REG_W-1:0]       pc,
    input  logic [N_REG-1:0]       sel,
    input  logic [1:0]             mode,
    input  logic [2:0]             page,
    input  logic                   freeze,
    input  logic                   blank_lz,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [N_DIG-1:0]       an,
    output logic                   sel_err
);

    localparam int PW  = $clog2(SCAN_DIV);
    localparam int DW  = $clog2(N_DIG);
    localparam int NIB = REG_W / 4;

    logic [PW-1:0]      presc_q, presc_d;
    logic [DW-1:0]      dig_q, dig_d;
    logic [N_DIG*4-1:0] snap_q, val_d;
    logic               sel_err_q;
    logic [6:0]         seg_q, seg_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic               dp_q, dp_d;

    logic               sel_ok;
    logic [REG_W-1:0]   reg_sel;
    logic               blank_en;
    logic               zrun;
    logic [N_DIG-1:0]   blank;
    logic [3:0]         cur_nib;

    // Nibbles past the top of the source read as zero rather than wrapping.
    function automatic logic [3:0] nib_at(input logic [REG_W-1:0] src, input int unsigned idx);
        nib_at = (idx < NIB) ? src[idx*4 +: 4] : 4'h0;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        sel_ok  = (sel != '0) && ((sel & (sel - N_REG'(1))) == '0);
        reg_sel = '0;
        for (int unsigned k = 0; k < N_REG; k++) begin
            if (sel[k]) reg_sel = reg_sel | rf[k*REG_W +: REG_W];
        end
        if (!sel_ok) reg_sel = '0;
    end

    always_comb begin
        val_d = '0;
        for (int unsigned i = 0; i < N_DIG; i++) begin
            case (mode)
                2'b00: val_d[i*4 +: 4] = (i < N_DIG/2) ? nib_at(reg_sel, i)
                                                       : nib_at(pc, i - N_DIG/2);
                2'b01: val_d[i*4 +: 4] = nib_at(reg_sel, page*N_DIG + i);
                2'b10: val_d[i*4 +: 4] = nib_at(pc, page*N_DIG + i);
                default: val_d[i*4 +: 4] = 4'(i);
            endcase
        end
    end

    // Walk from the top digit down; blanking stops at the first non-zero nibble.
    always_comb begin
        blank_en = blank_lz && (mode == 2'b01 || mode == 2'b10);
        blank    = '0;
        zrun     = 1'b1;
        for (int unsigned j = 0; j < N_DIG; j++) begin
            zrun = zrun && (snap_q[(N_DIG-1-j)*4 +: 4] == 4'h0);
            if (blank_en && zrun && (j != N_DIG-1)) blank[N_DIG-1-j] = 1'b1;
        end
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        dig_d   = dig_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            dig_d   = (dig_q == DW'(N_DIG - 1)) ? '0 : dig_q + DW'(1);
        end
        cur_nib = snap_q[{dig_q, 2'b00} +: 4];
        seg_d   = hex7(cur_nib);
        an_d    = blank[dig_q] ? '1 : ~(N_DIG'(1) << dig_q);
        dp_d    = !((dig_q == '0) && freeze);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q   <= '0;
            dig_q     <= '0;
            snap_q    <= '0;
            sel_err_q <= 1'b0;
            an_q      <= '1;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            dig_q     <= dig_d;
            sel_err_q <= !sel_ok;
            if (!freeze) snap_q <= val_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign dp      = dp_q;
    assign sel_err = sel_err_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIG, default 4: number of digits scanned; even, 2..8.
REQ-002 SHALL have parameter N_REG, default 15: number of registers on the flattened bus.
REQ-003 SHALL have parameter REG_W, default 32: register and PC width; a multiple of 4.
REQ-004 SHALL have parameter SCAN_DIV, default 1024: clk cycles per digit slot; at least 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port rf, input, N_REG*REG_W bits: flattened registers; register k is at rf[k*REG_W +: REG_W].
REQ-008 SHALL have port pc, input, REG_W bits: program counter value to display.
REQ-009 SHALL have port sel, input, N_REG bits: one-hot register select.
REQ-010 SHALL have port mode, input, 2 bits: display mode.
REQ-011 SHALL have port page, input, 3 bits: nibble-window index for modes 01 and 10.
REQ-012 SHALL have port freeze, input, 1 bit: 1 holds the displayed value.
REQ-013 SHALL have port blank_lz, input, 1 bit: 1 enables leading-zero blanking.
REQ-014 SHALL have port seg, output, 7 bits: active-low segments, seg[0]=a through seg[6]=g.
REQ-015 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-016 SHALL have port an, output, N_DIG bits: active-low anodes; an[0] is the rightmost digit.
REQ-017 SHALL have port sel_err, output, 1 bit: 1 when sel is not one-hot.

Function
REQ-018 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; digit index d SHALL advance mod N_DIG on the edge where the prescaler wraps.
REQ-019 Selected register R SHALL be rf of the single set sel bit; zero or several set bits SHALL give R=0 and sel_err=1, registered with 1-cycle latency.
REQ-020 Live value V SHALL be N_DIG nibbles, by mode:
- 00: upper N_DIG/2 nibbles = pc low nibbles; lower N_DIG/2 nibbles = R low nibbles.
- 01: R nibbles [page*N_DIG .. page*N_DIG+N_DIG-1].
- 10: same window as 01, taken from pc.
- 11: test pattern; digit i shows value i.
REQ-021 Any window nibble at or above index REG_W/4 SHALL read 0; no wrap into low nibbles.
REQ-022 Snapshot register S SHALL load V every cycle while freeze=0 and SHALL hold while freeze=1; the first held value is V from the cycle freeze was sampled 1.
REQ-023 Leading-zero blanking, active only when blank_lz=1 and mode is 01 or 10:
- digit i is blanked (an[i]=1) when every nibble of S at index i and above is 0;
- digit 0 is never blanked.
REQ-024 seg SHALL be standard hex coding of S nibble d: 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.
REQ-025 an SHALL be all ones except bit d, or all ones when digit d is blanked.
REQ-026 dp SHALL be 0 only when d=0 and freeze=1; otherwise 1.
REQ-027 seg, an and dp SHALL be registered and reflect d, S and blanking one cycle after they change.
REQ-028 mode, page and sel changes SHALL take effect in S on the next cycle when not frozen; the scan counters are not disturbed.

Reset
REQ-029 While reset=0 at a clk edge, SHALL set prescaler=0, d=0, S=0, sel_err=0, an=all ones, seg=7'h7F, dp=1.
REQ-030 Reset mid-scan or mid-freeze SHALL apply REQ-029 on that edge; normal scan resumes with d=0 on the first edge with reset=1.

Verification
REQ-031 Scan timing: SCAN_DIV=4, N_DIG=4, mode 11 -> an steps 1110, 1101, 1011, 0111 every 4 cycles; seg shows 0, 1, 2, 3 in turn.
REQ-032 Mode 00: pc=0x000000A5, sel=1 selects register 0 = 0x0000003C -> digits (digit 3 down to digit 0) show A, 5, 3, C.
REQ-033 Select error: sel=0 or sel=0b11 -> sel_err=1 one cycle later; register digits show 0.
REQ-034 Paging: mode 01, R=0x12345678, N_DIG=4:
- page 1 -> 1, 2, 3, 4;
- page 2 -> 0, 0, 0, 0 (window beyond REG_W reads 0).
REQ-035 Blanking and freeze:
- mode 01, R=0x00000007, blank_lz=1 -> an[3:1] stay 1 and only digit 0 shows 7;
- then assert freeze and change R -> display is unchanged and dp=0 on digit 0.
REQ-036 Reset: pull reset low for 1 cycle mid-scan -> next edge gives an=all ones, seg=7'h7F; scan restarts at digit 0.
